// File: rtl/rv32_types.sv
// Shared RV32 pipeline types used by the fetch stage and its neighbours.
package rv32_types;

  typedef logic [31:0] rv32_word;

  // Canonical NOP encoding (addi x0, x0, 0) that decode substitutes on a bubble.
  localparam rv32_word RV_NOP = 32'h0000_0013;

  typedef struct packed {
    rv32_word pc;
    logic     generate_nop;
  } fetch_decode_buffer_t;

  typedef struct packed {
    logic     do_jump;
    rv32_word from;
    rv32_word to;
  } jump_request_t;

  typedef struct packed {
    logic     do_interrupt;
    rv32_word from;
    rv32_word to;
  } interrupt_request_t;

endpackage

// File: rtl/rv32_fetch_stage_pc_select.sv
// Fetch address priority mux: stop > interrupt > jump > stall > sequential.
module rv32_pc_select
  import rv32_types::*;
(
  input  logic               stop,
  input  logic               stall,
  input  jump_request_t      jump_request,
  input  interrupt_request_t interrupt_request,
  input  rv32_word           held_pc,
  input  rv32_word           pc_q,
  output rv32_word           sel_addr,
  output logic               redirect
);

  // The source addresses of redirects are carried for trace only.
  logic unused_from;
  assign unused_from = ^{jump_request.from, interrupt_request.from};

  // Pick the raw (unaligned) fetch address; flag when a redirect is taken.
  always_comb begin
    sel_addr = pc_q;
    redirect = 1'b0;
    if (stop) begin
      sel_addr = held_pc;
    end else if (interrupt_request.do_interrupt) begin
      sel_addr = interrupt_request.to;
      redirect = 1'b1;
    end else if (jump_request.do_jump) begin
      sel_addr = jump_request.to;
      redirect = 1'b1;
    end else if (stall) begin
      sel_addr = held_pc;
    end
  end

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: drives the instruction memory address and
// hands the fetched pc (aligned with memory data) to decode.
module rv32_fetch_stage
  import rv32_types::*;
#(
  parameter rv32_word RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stop,
  input  logic                 stall,
  input  jump_request_t        jump_request,
  input  interrupt_request_t   interrupt_request,
  output rv32_word             instr_addr,
  output logic                 instr_req,
  input  logic                 instr_ready,
  output fetch_decode_buffer_t fetch_decode_buff,
  output logic                 fetch_misaligned,
  output rv32_word             fetch_count,
  output rv32_word             bubble_count
);

  rv32_word pc_q;
  rv32_word sel_addr;
  logic     redirect;

  rv32_pc_select u_pc_select (
    .stop              (stop),
    .stall             (stall),
    .jump_request      (jump_request),
    .interrupt_request (interrupt_request),
    .held_pc           (fetch_decode_buff.pc),
    .pc_q              (pc_q),
    .sel_addr          (sel_addr),
    .redirect          (redirect)
  );

  // Reset forces the reset vector onto the bus; otherwise word-align the selection.
  always_comb begin
    instr_req  = !reset;
    instr_addr = reset ? RESET_PC : {sel_addr[31:2], 2'b00};
  end

  // All fetch state: next pc, decode buffer, sticky misalign flag, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q                           <= RESET_PC;
      fetch_decode_buff.pc           <= RESET_PC;
      fetch_decode_buff.generate_nop <= 1'b1;
      fetch_misaligned               <= 1'b0;
      fetch_count                    <= '0;
      bubble_count                   <= '0;
    end else if (!stop) begin
      fetch_decode_buff.pc           <= instr_addr;
      fetch_decode_buff.generate_nop <= !instr_ready;
      // An unaccepted address is retried next cycle rather than skipped.
      pc_q <= instr_ready ? instr_addr + 32'd4 : instr_addr;
      if (redirect && (sel_addr[1:0] != 2'b00)) begin
        fetch_misaligned <= 1'b1;
      end
      if (instr_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end else begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
module tb_rv32_fetch_stage;
  import rv32_types::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 stop;
  logic                 stall;
  jump_request_t        jump_request;
  interrupt_request_t   interrupt_request;
  rv32_word             instr_addr;
  logic                 instr_req;
  logic                 instr_ready;
  fetch_decode_buffer_t fetch_decode_buff;
  logic                 fetch_misaligned;
  rv32_word             fetch_count;
  rv32_word             bubble_count;

  rv32_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk               (clk),
    .reset             (reset),
    .stop              (stop),
    .stall             (stall),
    .jump_request      (jump_request),
    .interrupt_request (interrupt_request),
    .instr_addr        (instr_addr),
    .instr_req         (instr_req),
    .instr_ready       (instr_ready),
    .fetch_decode_buff (fetch_decode_buff),
    .fetch_misaligned  (fetch_misaligned),
    .fetch_count       (fetch_count),
    .bubble_count      (bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     stop;
    logic     stall;
    logic     do_jump;
    rv32_word jto;
    logic     do_irq;
    rv32_word ito;
    logic     rdy;
    rv32_word exp_addr;
    rv32_word exp_pc;
    logic     exp_nop;
    logic     exp_mis;
  } vec_t;

  typedef struct {
    rv32_word pc;
    logic     nop;
    logic     mis;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic s, logic st, logic j, rv32_word jt, logic ir,
                              rv32_word it, logic r, rv32_word ea, rv32_word ep,
                              logic en, logic em);
    vec_t v;
    v.stop = s; v.stall = st; v.do_jump = j; v.jto = jt; v.do_irq = ir; v.ito = it;
    v.rdy = r; v.exp_addr = ea; v.exp_pc = ep; v.exp_nop = en; v.exp_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input rv32_word act, input rv32_word exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stop                           = v.stop;
    stall                          = v.stall;
    jump_request.do_jump           = v.do_jump;
    jump_request.from              = 32'h0000_0ABC;
    jump_request.to                = v.jto;
    interrupt_request.do_interrupt = v.do_irq;
    interrupt_request.from         = 32'h0000_0DEF;
    interrupt_request.to           = v.ito;
    instr_ready                    = v.rdy;
  endtask

  // One clock: drive, check combinational address, push expectation, compare after edge.
  task automatic step(input vec_t v, input string nm);
    sb_t e;
    sb_t g;
    drive(v);
    #1;
    chk({nm, ".instr_addr"}, instr_addr, v.exp_addr);
    chk({nm, ".instr_req"}, {31'b0, instr_req}, 32'd1);
    e.pc = v.exp_pc; e.nop = v.exp_nop; e.mis = v.exp_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s.scoreboard: queue empty", nm);
    end else begin
      g = sb.pop_front();
      chk({nm, ".pc"}, fetch_decode_buff.pc, g.pc);
      chk({nm, ".nop"}, {31'b0, fetch_decode_buff.generate_nop}, {31'b0, g.nop});
      chk({nm, ".misaligned"}, {31'b0, fetch_misaligned}, {31'b0, g.mis});
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".pc"}, fetch_decode_buff.pc, 32'h100);
    chk({nm, ".nop"}, {31'b0, fetch_decode_buff.generate_nop}, 32'd1);
    chk({nm, ".misaligned"}, {31'b0, fetch_misaligned}, 32'd0);
    chk({nm, ".fetch_count"}, fetch_count, 32'd0);
    chk({nm, ".bubble_count"}, bubble_count, 32'd0);
    chk({nm, ".instr_req"}, {31'b0, instr_req}, 32'd0);
    chk({nm, ".instr_addr"}, instr_addr, 32'h100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            stop st jmp jto           irq ito           rdy addr          pc            nop mis
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      32'h100,      0, 0)); // 0
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h104,      32'h104,      0, 0)); // 1
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h108,      32'h108,      1, 0)); // 2
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h108,      32'h108,      1, 0)); // 3
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h108,      32'h108,      0, 0)); // 4
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10C,      32'h10C,      0, 0)); // 5
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h10C,      32'h10C,      0, 0)); // 6
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h10C,      32'h10C,      0, 0)); // 7
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h10C,      32'h10C,      0, 0)); // 8
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h110,      32'h110,      0, 0)); // 9
    tbl.push_back(mk(0, 1, 1, 32'h200,      1, 32'h40,       1, 32'h040,      32'h040,      0, 0)); // 10
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h044,      32'h044,      0, 0)); // 11
    tbl.push_back(mk(0, 0, 1, 32'h300,      0, 32'h0,        1, 32'h300,      32'h300,      0, 0)); // 12
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h300,      32'h300,      1, 0)); // 13
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h300,      32'h300,      0, 0)); // 14
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h304,      32'h304,      0, 0)); // 15
    tbl.push_back(mk(0, 0, 1, 32'h202,      0, 32'h0,        1, 32'h200,      32'h200,      0, 1)); // 16
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      32'h204,      0, 1)); // 17
    tbl.push_back(mk(1, 0, 1, 32'h500,      0, 32'h0,        1, 32'h204,      32'h204,      0, 1)); // 18
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h601,      0, 32'h204,      32'h204,      0, 1)); // 19
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      32'h204,      0, 1)); // 20
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h204,      32'h204,      0, 1)); // 21
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h208,      32'h208,      0, 1)); // 22

    // Reset with every other control asserted: reset must win.
    reset = 1'b1;
    drive(mk(1, 1, 1, 32'h300, 1, 32'h400, 1, 32'h0, 32'h0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i], $sformatf("vec%0d", i));
      if (i == 3) chk("ready_low.bubble_count", bubble_count, 32'd2);
      if (i == 17) chk("pre_stop.fetch_count", fetch_count, 32'd15);
      if (i == 21) begin
        chk("stop.fetch_count", fetch_count, 32'd15);
        chk("stop.bubble_count", bubble_count, 32'd3);
      end
    end
    chk("table.fetch_count", fetch_count, 32'd16);
    chk("table.bubble_count", bubble_count, 32'd3);

    // Address wrap at the top of the address space.
    step(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1), "wrap_a");
    step(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0000_0000, 32'h0000_0000, 0, 1), "wrap_b");
    step(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0000_0004, 32'h0000_0004, 0, 1), "wrap_c");

    // Misaligned interrupt target is aligned on the bus.
    step(mk(0, 0, 0, 32'h0, 1, 32'h0000_0083, 1, 32'h0000_0080, 32'h0000_0080, 0, 1), "irq_mis");

    // Reset asserted while stopped: return to the reset vector and clear everything.
    drive(mk(1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("reset_in_stop");
    reset = 1'b0;
    step(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h100, 32'h100, 0, 0), "post_reset_a");
    step(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h104, 32'h104, 0, 0), "post_reset_b");
    chk("post_reset.fetch_count", fetch_count, 32'd2);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
